// File: rtl/conv_code_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 (7,5) convolutional code.
package conv_code_pkg;

  localparam int         K          = 3;
  localparam int         NUM_STATES = 1 << (K - 1);
  localparam logic [2:0] G0         = 3'b111;
  localparam logic [2:0] G1         = 3'b101;
  localparam int         INIT_BIAS  = 4;

  function automatic logic parity3(input logic [2:0] v);
    return ^v;
  endfunction

  // Encoder register is {u, s1, s0}; result is {c0, c1}.
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
    logic [2:0] reg_v;
    reg_v = {u, state};
    return {parity3(reg_v & G0), parity3(reg_v & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/acs_unit.sv
// Add-compare-select for one trellis state; ties select predecessor a (s0=0).
module acs_unit #(
  parameter int MW = 4
) (
  input  logic [MW-1:0] pm_a,
  input  logic [MW-1:0] pm_b,
  input  logic [1:0]    bm_a,
  input  logic [1:0]    bm_b,
  output logic [MW:0]   metric,
  output logic          dec
);

  logic [MW:0] cand_a_s;
  logic [MW:0] cand_b_s;

  // Candidates at MW+1 bits so the add can never wrap.
  always_comb begin
    cand_a_s = {1'b0, pm_a} + {{(MW-1){1'b0}}, bm_a};
    cand_b_s = {1'b0, pm_b} + {{(MW-1){1'b0}}, bm_b};
    if (cand_b_s < cand_a_s) begin
      metric = cand_b_s;
      dec    = 1'b1;
    end else begin
      metric = cand_a_s;
      dec    = 1'b0;
    end
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder, 4 states, fixed latency D.
// Optional channel-error counter on port err_cnt when VITERBI_ERRCNT_EN is defined.
module viterbi_decoder
  import conv_code_pkg::*;
#(
  parameter int D  = 16,
  parameter int MW = 4
) (
  input  logic       clk_sig,
  input  logic       reset_sig,
  input  logic       sync_clr,
  input  logic       in_valid,
  input  logic [1:0] in_sym,
  output logic       out_valid,
  output logic       out_bit
`ifdef VITERBI_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int            CW    = $clog2(D + 1);
  localparam logic [CW-1:0] D_CNT = CW'(D);
  localparam logic [MW-1:0] BIAS  = MW'(INIT_BIAS);

  // Only the D-1 newest survivor bits are stored; the oldest leaves as out_bit.
  logic [MW-1:0] pm_r        [NUM_STATES];
  logic [D-2:0]  surv_r      [NUM_STATES];
  logic [CW-1:0] cnt_r;
  logic          out_valid_r;
  logic          out_bit_r;

  logic [MW:0]   raw_s       [NUM_STATES];
  logic          dec_s       [NUM_STATES];
  logic [MW:0]   min_s;
  logic [MW-1:0] pm_next_s   [NUM_STATES];
  logic [D-1:0]  surv_next_s [NUM_STATES];
  logic [1:0]    best_s;
  logic [CW-1:0] cnt_next_s;

  for (genvar d = 0; d < NUM_STATES; d++) begin : g_acs
    localparam logic [1:0] DST = 2'(d);
    localparam logic [1:0] PA  = {DST[0], 1'b0};
    localparam logic [1:0] PB  = {DST[0], 1'b1};

    logic [1:0] bm_a_s;
    logic [1:0] bm_b_s;

    assign bm_a_s = hamming2(in_sym, exp_sym(PA, DST[1]));
    assign bm_b_s = hamming2(in_sym, exp_sym(PB, DST[1]));

    acs_unit #(.MW(MW)) u_acs (
      .pm_a   (pm_r[PA]),
      .pm_b   (pm_r[PB]),
      .bm_a   (bm_a_s),
      .bm_b   (bm_b_s),
      .metric (raw_s[d]),
      .dec    (dec_s[d])
    );
  end

  // Normalise metrics, exchange survivors and pick the best state.
  always_comb begin
    min_s = raw_s[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (raw_s[s] < min_s) begin
        min_s = raw_s[s];
      end else begin
        min_s = min_s;
      end
    end

    for (int s = 0; s < NUM_STATES; s++) begin
      pm_next_s[s]   = MW'(raw_s[s] - min_s);
      surv_next_s[s] = {surv_r[{s[0], dec_s[s]}], s[1]};
    end

    best_s = 2'd0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm_next_s[s] < pm_next_s[best_s]) begin
        best_s = 2'(s);
      end else begin
        best_s = best_s;
      end
    end

    if (cnt_r == D_CNT) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  // Trellis state, warm-up counter and registered outputs.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_r[s]   <= (s == 0) ? {MW{1'b0}} : BIAS;
        surv_r[s] <= {(D-1){1'b0}};
      end
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
    end else if (sync_clr) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_r[s]   <= (s == 0) ? {MW{1'b0}} : BIAS;
        surv_r[s] <= {(D-1){1'b0}};
      end
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
    end else if (in_valid) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_r[s]   <= pm_next_s[s];
        surv_r[s] <= surv_next_s[s][D-2:0];
      end
      cnt_r       <= cnt_next_s;
      out_valid_r <= (cnt_next_s >= D_CNT);
      out_bit_r   <= surv_next_s[best_s][D-1];
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_bit   = out_bit_r;

`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt_r;
  logic [16:0] err_sum_s;
  logic [15:0] err_next_s;

  // The pre-normalisation minimum is the best path's error increment.
  always_comb begin
    err_sum_s = {1'b0, err_cnt_r} + 17'(min_s);
    if (err_sum_s[16]) begin
      err_next_s = 16'hFFFF;
    end else begin
      err_next_s = err_sum_s[15:0];
    end
  end

  // Saturating error accumulator.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      err_cnt_r <= 16'h0000;
    end else if (sync_clr) begin
      err_cnt_r <= 16'h0000;
    end else if (in_valid) begin
      err_cnt_r <= err_next_s;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed scoreboard bench for viterbi_decoder (default D=16, MW=4).
module tb_viterbi_decoder;

  localparam int D = 16;

  logic       clk_sig = 1'b0;
  logic       reset_sig;
  logic       sync_clr;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       out_valid;
  logic       out_bit;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_pulse = 0;
  int   mcnt    = 0;
  logic q[$];

  viterbi_decoder #(.D(D), .MW(4)) dut (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .out_valid (out_valid),
    .out_bit   (out_bit)
`ifdef VITERBI_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk_sig = ~clk_sig;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic info_bit(input logic [5:0] pat, input int j);
    return (j < 6) ? pat[5-j] : 1'b0;
  endfunction

  // Output monitor: independent warm-up count model plus scoreboard pop.
  always @(posedge clk_sig) begin
    logic acc;
    logic exp_ov;
    logic eb;
    acc = reset_sig && !sync_clr && in_valid;
    if (!reset_sig || sync_clr) mcnt = 0;
    else if (in_valid && mcnt < D) mcnt++;
    exp_ov = acc && (mcnt >= D);
    #1;
    check("out_valid", 16'(out_valid), 16'(exp_ov));
    if (out_valid === 1'b1) begin
      n_pulse++;
      eb = (q.size() != 0) ? q.pop_front() : 1'bx;
      check("out_bit", 16'(out_bit), 16'(eb));
    end
  end

  task automatic frame(input logic [5:0] pat, input int nsym, input bit corrupt, input int maxgap);
    logic [1:0] st;
    logic [1:0] sym;
    logic       u;
    st = 2'b00;
    for (int i = 0; i < nsym; i++) begin
      u   = info_bit(pat, i);
      sym = {u ^ st[1] ^ st[0], u ^ st[0]};
      st  = {u, st[1]};
      if (corrupt && i == 2) sym = 2'b10;
      if (i > 0) begin
        repeat ($urandom_range(maxgap, 0)) begin
          @(negedge clk_sig);
          in_valid = 1'b0;
        end
      end
      @(negedge clk_sig);
      in_valid = 1'b1;
      in_sym   = sym;
      if (i >= D - 1) q.push_back(info_bit(pat, i - D + 1));
    end
    @(posedge clk_sig);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk_sig);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    in_sym   = 2'b11;
    @(negedge clk_sig);
    sync_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int pulses);
    repeat (4) @(negedge clk_sig);
    check({tag, "_queue_left"}, 16'(q.size()), 16'd0);
    check({tag, "_pulses"}, 16'(n_pulse), 16'(pulses));
  endtask

  initial begin
    reset_sig = 1'b0;
    sync_clr  = 1'b0;
    in_valid  = 1'b0;
    in_sym    = 2'b00;
    repeat (2) @(negedge clk_sig);
    reset_sig = 1'b1;
    @(negedge clk_sig);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_bit", 16'(out_bit), 16'd0);
`ifdef VITERBI_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 16'd0);
`endif

    // All-zero stream: 25 zero outputs.
    n_pulse = 0;
    frame(6'b000000, 40, 1'b0, 0);
    drain("zeros", 25);
`ifdef VITERBI_ERRCNT_EN
    check("zeros_err_cnt", err_cnt, 16'd0);
`endif

    // Clean 1,0,1,1,0,0 frame.
    clr();
    n_pulse = 0;
    frame(6'b101100, 30, 1'b0, 0);
    drain("clean", 15);
`ifdef VITERBI_ERRCNT_EN
    check("clean_err_cnt", err_cnt, 16'd0);
`endif

    // Third symbol corrupted.
    clr();
    n_pulse = 0;
    frame(6'b101100, 30, 1'b1, 0);
    drain("corrupt", 15);
`ifdef VITERBI_ERRCNT_EN
    check("corrupt_err_cnt", err_cnt, 16'd1);
`endif

    // Idle gaps of 0..3 cycles.
    clr();
    n_pulse = 0;
    frame(6'b101100, 30, 1'b0, 3);
    drain("gaps", 15);

    // sync_clr mid-frame, then restart.
    clr();
    n_pulse = 0;
    frame(6'b101100, 10, 1'b0, 0);
    clr();
    check("sclr_out_bit", 16'(out_bit), 16'd0);
    frame(6'b101100, 30, 1'b0, 0);
    drain("sclr", 15);

    // Asynchronous reset while an output is valid.
    clr();
    n_pulse = 0;
    frame(6'b101100, 19, 1'b0, 0);
    check("pre_rst_out_valid", 16'(out_valid), 16'd1);
    check("pre_rst_out_bit", 16'(out_bit), 16'd1);
    reset_sig = 1'b0;
    #1;
    check("async_rst_out_valid", 16'(out_valid), 16'd0);
    check("async_rst_out_bit", 16'(out_bit), 16'd0);
`ifdef VITERBI_ERRCNT_EN
    check("async_rst_err_cnt", err_cnt, 16'd0);
`endif
    check("pre_rst_pulses", 16'(n_pulse), 16'd4);
    repeat (2) @(negedge clk_sig);
    reset_sig = 1'b1;
    n_pulse = 0;
    frame(6'b101100, 30, 1'b0, 1);
    drain("post_rst", 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7/5 octal) produced by the ConvCode encoder path. It accepts one 2-bit code symbol per valid cycle, runs add-compare-select over 4 trellis states, and keeps survivors by register exchange. It emits decoded bits at a fixed latency of D symbols and sits directly downstream of the channel/demapper model.

## Interface
- `D`, default 16: survivor depth in symbols; legal range 8..64.
- `MW`, default 4: path-metric width in bits; must be ≥ 3.
- `clk_sig`  in  1: clock; all logic on the rising edge.
- `reset_sig`  in  1: asynchronous, active-low reset.
- `sync_clr`  in  1: synchronous frame restart; same effect as reset, and has priority over `in_valid`.
- `in_valid`  in  1: `in_sym` is valid this cycle; there is no backpressure.
- `in_sym`  in  2: received symbol; bit1 = c0 (g=111), bit0 = c1 (g=101).
- `out_valid`  out  1: `out_bit` is valid; single-cycle pulse.
- `out_bit`  out  1: decoded information bit.
- `err_cnt`  out  16: channel-error estimate; present only with `VITERBI_ERRCNT_EN`.

## Operation
- Encoder convention:
  - State s = {s1,s0} = {u[n-1],u[n-2]}.
  - Outputs are c0 = u^s1^s0 and c1 = u^s0.
  - Next state is {u,s1}.
- Predecessors of state {u,s1} are {s1,0} and {s1,1}.
- Branch metric: Hamming distance between `in_sym` and the expected {c0,c1}; range 0..2.
- ACS, per state on each accepted symbol:
  - Candidate metric = pm[pred] + bm, computed at MW+1 bits.
  - Select the smaller candidate. On a tie, select the predecessor with s0=0.
- Normalisation: subtract the minimum of the 4 new metrics from all 4, then truncate to MW bits. The minimum state metric is therefore always 0, and the spread is always ≤ 4.
- Survivors: each state holds a D-bit register. The new survivor = {survivor[chosen pred][D-2:0], u}, where u is the MSB of the destination state.
- Output selection:
  - Best state = the state with minimum updated metric; ties go to the lowest index.
  - `out_bit` = bit D-1 (oldest) of the best state's updated survivor.
- Warm-up counter:
  - Counts accepted symbols from 0 and saturates at D.
  - `out_valid` is asserted only for accepted symbols whose post-increment count is ≥ D. The first output is therefore decoded bit 0, produced by the D-th accepted symbol.
- Reset and `sync_clr` values:
  - pm[0]=0; pm[1..3]=4.
  - All survivors = 0; counter = 0.
  - `out_valid`=0, `out_bit`=0, `err_cnt`=0.
- Reset or `sync_clr` mid-frame: the frame is abandoned and no flush outputs are produced. Upper layers must append K-1=2 tail zeros plus D-1 padding symbols to drain a frame.

## Timing
- `out_valid`/`out_bit` are registered on the same edge that accepts the symbol, so they are visible the cycle after `in_valid`.
- Back-to-back `in_valid` is sustained at 1 symbol/cycle.
- Decode latency: bit j appears in the cycle after symbol j+D-1 is accepted.
- `in_valid`=0: metrics, survivors, counter and `err_cnt` hold; `out_valid`=0; `out_bit` holds its last value.
- `sync_clr`=1 together with `in_valid`=1: the symbol is dropped and the clear wins.

## Configuration
- `VITERBI_ERRCNT_EN` defined:
  - Each accepted symbol adds the pre-normalisation minimum metric to `err_cnt` (0..2). This equals the best-path error increment.
  - `err_cnt` saturates at 16'hFFFF.
  - `err_cnt` is cleared by reset and `sync_clr`.
- Macro undefined: the `err_cnt` port and its logic are absent; all other behaviour is identical.

## Structure
- Package `conv_code_pkg`:
  - Constants K=3, NUM_STATES=4, G0=3'b111, G1=3'b101, INIT_BIAS=4.
  - A function returning the expected 2-bit symbol for (state, u).
- Sub-module `acs_unit`, instantiated 4×: inputs are two predecessor metrics and two branch metrics; outputs are the unnormalised new metric and the decision bit.
- Top level holds branch metrics, normaliser, survivor registers, best-state search, warm-up counter and `err_cnt`.

## Test plan
- Reset, then 40 symbols of 2'b00 back-to-back:
  - First `out_valid` in the cycle after symbol 16.
  - 25 output pulses, all `out_bit`=0.
  - `err_cnt`=0.
- Info bits 1,0,1,1,0,0 encoded as 11,10,00,01,01,11, followed by 2'b00 padding to 30 symbols: the first six outputs are 1,0,1,1,0,0.
- Same stream with the third symbol corrupted to 2'b10: outputs are unchanged; `err_cnt`=1.
- Same stream with `in_valid` gaps of 0–3 idle cycles between symbols: the output sequence is identical, and `out_valid` pulses only the cycle after accepted symbols.
- `sync_clr` pulsed after 10 symbols, then the clean 1,0,1,1,0,0 stream restarted: no output before 16 new symbols; decoded bits match.
- `reset_sig` asserted asynchronously mid-stream: all outputs go to 0 immediately; after release, the decoder behaves exactly as after power-up.
